// File: rtl/fpu_pack.sv
// fpu_pack: packs an unpacked floating-point value into an IEEE-754-style word.
// Two-stage valid/ready pipeline:
//   stage 1 - normalize (carry shift / leading-zero shift), denormalize tiny values
//   stage 2 - round per in_rm, detect overflow/underflow, select specials, write fields
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      input handshake (in_ready = !out_valid || out_ready)
//   in_sign, in_exp, in_mant unpacked operand (in_mant = carry, hidden, fraction, G, R, S)
//   in_is_nan/inf/zero       special-case flags, priority nan > inf > zero
//   in_rm                    0 RNE, 1 RTZ, 2 RUP, 3 RDN
//   out_valid / out_ready    output handshake
//   out_word                 packed result; out_overflow/underflow/inexact its flags
module fpu_pack #(
  parameter int unsigned SIGN_WIDTH        = 1,
  parameter int unsigned EXPONENT_WIDTH    = 11,
  parameter int unsigned SIGNIFICAND_WIDTH = 52
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic                                                in_sign,
  input  logic [EXPONENT_WIDTH+1:0]                           in_exp,
  input  logic [SIGNIFICAND_WIDTH+4:0]                        in_mant,
  input  logic                                                in_is_nan,
  input  logic                                                in_is_inf,
  input  logic                                                in_is_zero,
  input  logic [1:0]                                          in_rm,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic [SIGN_WIDTH+EXPONENT_WIDTH+SIGNIFICAND_WIDTH-1:0] out_word,
  output logic                                                out_overflow,
  output logic                                                out_underflow,
  output logic                                                out_inexact
);

  localparam int unsigned EW  = EXPONENT_WIDTH;
  localparam int unsigned SW  = SIGNIFICAND_WIDTH;
  localparam int unsigned NW  = SW + 4;            // hidden + fraction + G/R/S
  localparam int unsigned XW  = EW + 4;            // internal signed exponent
  localparam int unsigned LZW = $clog2(NW + 1);
  localparam int unsigned SHW = $clog2(SW + 6);
  localparam int unsigned OW  = SIGN_WIDTH + EW + SW;

  localparam logic [1:0] RmRne = 2'd0;
  localparam logic [1:0] RmRtz = 2'd1;
  localparam logic [1:0] RmRup = 2'd2;
  localparam logic [1:0] RmRdn = 2'd3;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------------------------------------------------------- stage 1
  logic [NW-1:0]        mant_low;
  logic                 mant_zero;
  logic [LZW-1:0]       lzc;
  logic                 lz_found;
  logic signed [XW-1:0] exp_in_x;
  logic signed [XW-1:0] norm_exp;
  logic [NW-1:0]        norm_mant;
  logic                 tiny;
  logic [XW-1:0]        shamt_x;
  logic [SHW-1:0]       shamt;
  logic [NW-1:0]        sub_mask;
  logic                 sub_lost;
  logic [NW-1:0]        s1_mant_d;
  logic [EW+1:0]        s1_exp_d;

  assign mant_low  = in_mant[NW-1:0];
  assign mant_zero = (in_mant == '0);
  assign exp_in_x  = {{2{in_exp[EW+1]}}, in_exp};

  always_comb begin
    lzc      = '0;
    lz_found = 1'b0;
    for (int i = NW - 1; i >= 0; i--) begin
      if (!lz_found) begin
        if (mant_low[i]) lz_found = 1'b1;
        else             lzc      = lzc + LZW'(1);
      end
    end
  end

  always_comb begin
    norm_mant = mant_low;
    norm_exp  = exp_in_x;
    if (in_mant[NW]) begin
      // Carry: shift right one, the bit falling off joins sticky.
      norm_mant = {in_mant[NW:2], in_mant[1] | in_mant[0]};
      norm_exp  = exp_in_x + XW'(1);
    end else begin
      norm_mant = mant_low << lzc;
      norm_exp  = exp_in_x - XW'(lzc);
    end
  end

  always_comb begin
    tiny      = norm_exp[XW-1] || (norm_exp == '0);
    shamt_x   = XW'(1) - norm_exp;
    shamt     = '0;
    sub_mask  = '0;
    sub_lost  = 1'b0;
    s1_mant_d = norm_mant;
    s1_exp_d  = norm_exp[EW+1:0];
    if (tiny) begin
      shamt     = (shamt_x > XW'(SW + 5)) ? SHW'(SW + 5) : shamt_x[SHW-1:0];
      sub_mask  = (shamt >= SHW'(NW)) ? '1 : ((NW'(1) << shamt) - NW'(1));
      sub_lost  = |(norm_mant & sub_mask);
      s1_mant_d = (norm_mant >> shamt) | NW'(sub_lost);
      s1_exp_d  = '0;
    end
  end

  logic          s1_valid;
  logic          s1_sign;
  logic [EW+1:0] s1_exp;
  logic [NW-1:0] s1_mant;
  logic          s1_tiny;
  logic [1:0]    s1_rm;
  logic          s1_nan;
  logic          s1_inf;
  logic          s1_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_mant  <= '0;
      s1_tiny  <= 1'b0;
      s1_rm    <= '0;
      s1_nan   <= 1'b0;
      s1_inf   <= 1'b0;
      s1_zero  <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_sign  <= in_sign;
      s1_exp   <= s1_exp_d;
      s1_mant  <= s1_mant_d;
      s1_tiny  <= tiny;
      s1_rm    <= in_rm;
      s1_nan   <= in_is_nan;
      s1_inf   <= in_is_inf;
      s1_zero  <= in_is_zero || mant_zero;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic          rnd_g;
  logic          rnd_r;
  logic          rnd_s;
  logic          rnd_lsb;
  logic          rnd_any;
  logic          inc;
  logic [SW+1:0] sig;
  logic [EW+1:0] fin_exp;
  logic [SW-1:0] fin_frac;
  logic          ovf;
  logic          rounds_away;
  logic [OW-1:0] word_d;
  logic          ovf_d;
  logic          udf_d;
  logic          inx_d;

  assign rnd_lsb = s1_mant[3];
  assign rnd_g   = s1_mant[2];
  assign rnd_r   = s1_mant[1];
  assign rnd_s   = s1_mant[0];
  assign rnd_any = rnd_g | rnd_r | rnd_s;

  always_comb begin
    inc = 1'b0;
    unique case (s1_rm)
      RmRne: inc = rnd_g & (rnd_r | rnd_s | rnd_lsb);
      RmRtz: inc = 1'b0;
      RmRup: inc = !s1_sign & rnd_any;
      RmRdn: inc = s1_sign & rnd_any;
    endcase
  end

  always_comb begin
    sig = {1'b0, s1_mant[NW-1:3]} + (SW + 2)'(inc);
    if (sig[SW+1]) begin
      fin_exp = s1_exp + (EW + 2)'(1);
    end else if ((s1_exp == '0) && sig[SW]) begin
      // Subnormal rounded up into the hidden bit becomes the smallest normal.
      fin_exp = (EW + 2)'(1);
    end else begin
      fin_exp = s1_exp;
    end
    fin_frac    = sig[SW+1] ? '0 : sig[SW-1:0];
    ovf         = fin_exp >= {2'b00, {EW{1'b1}}};
    rounds_away = (s1_rm == RmRne) || ((s1_rm == RmRup) && !s1_sign) ||
                  ((s1_rm == RmRdn) && s1_sign);
  end

  always_comb begin
    word_d = {s1_sign, fin_exp[EW-1:0], fin_frac};
    ovf_d  = 1'b0;
    udf_d  = s1_tiny & rnd_any;
    inx_d  = rnd_any;
    if (s1_nan) begin
      word_d = {1'b0, {EW{1'b1}}, 1'b1, {(SW - 1){1'b0}}};
      udf_d  = 1'b0;
      inx_d  = 1'b0;
    end else if (s1_inf) begin
      word_d = {s1_sign, {EW{1'b1}}, {SW{1'b0}}};
      udf_d  = 1'b0;
      inx_d  = 1'b0;
    end else if (s1_zero) begin
      word_d = {s1_sign, {(EW + SW){1'b0}}};
      udf_d  = 1'b0;
      inx_d  = 1'b0;
    end else if (ovf) begin
      word_d = rounds_away ? {s1_sign, {EW{1'b1}}, {SW{1'b0}}}
                           : {s1_sign, {(EW - 1){1'b1}}, 1'b0, {SW{1'b1}}};
      ovf_d  = 1'b1;
      inx_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_word      <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
    end else if (adv) begin
      out_valid     <= s1_valid;
      out_word      <= word_d;
      out_overflow  <= ovf_d;
      out_underflow <= udf_d;
      out_inexact   <= inx_d;
    end
  end

endmodule

// File: doc/fpu_pack.md
# fpu_pack

Packs an unpacked floating-point value (sign, wide signed biased exponent, extended significand with guard/round/sticky bits, special-case flags) into an IEEE-754-style word of the configured format. It normalizes, handles subnormals, rounds per a selectable mode, detects overflow and underflow, and writes the output fields. It sits at the back end of every FPU arithmetic datapath, as the inverse of the unpack stage. It is a 2-stage valid/ready pipeline.

## Interface
- SIGN_WIDTH, 1, sign field width (fixed at 1)
- EXPONENT_WIDTH, 11, biased exponent field width; BIAS = 2^(EXPONENT_WIDTH-1)-1
- SIGNIFICAND_WIDTH, 52, stored fraction width (SW)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input word valid
- in_ready  out  1  input accepted when in_valid && in_ready
- in_sign  in  1  sign
- in_exp  in  EXPONENT_WIDTH+2  signed biased exponent
- in_mant  in  SW+5  bit SW+4 = carry, bit SW+3 = hidden, bits SW+2..3 = fraction, bit 2 = guard, bit 1 = round, bit 0 = sticky
- in_is_nan, in_is_inf, in_is_zero  in  1 each  special-case flags; priority nan > inf > zero
- in_rm  in  2  rounding mode: 0 RNE, 1 RTZ, 2 RUP (+inf), 3 RDN (-inf)
- out_valid  out  1  output valid
- out_ready  in  1  downstream ready
- out_word  out  SIGN_WIDTH+EXPONENT_WIDTH+SW  packed result
- out_overflow, out_underflow, out_inexact  out  1 each  exception flags for out_word

## Operation
- Value represented = (-1)^sign × in_mant/2^(SW+3) × 2^(in_exp-BIAS).
- Stage 1 (normalize):
  - Carry set: shift right 1, OR the shifted-out bit into sticky, exp+1.
  - Otherwise: leading-zero count on bits SW+3..0; shift left until hidden = 1 and subtract the count from exp.
  - Mant = 0 with no special flag is treated as zero.
- Stage 1 (subnormal): if normalized exp ≤ 0, shift right by 1-exp, capped at SW+5. All shifted-out bits OR into sticky. Exp field = 0. tiny = 1.
- Stage 2 (round):
  - inc is set when:
    - RNE: G && (R || S || lsb)
    - RUP: !sign && (G||R||S)
    - RDN: sign && (G||R||S)
    - RTZ: never
  - inexact = G||R||S.
  - Rounding carry out of the hidden bit gives exp+1 and fraction 0.
  - A subnormal that rounds up into the hidden bit gives exp field 1.
- Overflow: final exp ≥ 2^EXPONENT_WIDTH-1.
  - Result is ±inf when the mode rounds away: RNE, RUP for +, RDN for -.
  - Otherwise result is ±max-finite.
  - out_overflow = 1, out_inexact = 1.
- out_underflow = tiny && inexact (tininess detected before rounding).
- Specials bypass rounding:
  - nan gives canonical quiet NaN: sign 0, exp all-ones, fraction MSB 1, rest 0.
  - inf gives ±inf.
  - zero gives signed zero.
  - All flags are 0 for specials.
- Exp field width: only the low EXPONENT_WIDTH bits of the final exp are written, after range checks.

## Timing
- Latency: 2 cycles from the accept edge to out_valid, with no stalls.
- Global enable: adv = !out_valid || out_ready; in_ready = adv.
- Both stage registers load only when adv is high.
- Stalled: out_word and flags hold stable while out_valid && !out_ready.
- Bubbles do not collapse while stalled.
- Throughput: 1 result per cycle when out_ready is held high.
- Reset: stage valids = 0, out_valid = 0, out_word = 0, all flags = 0, in_ready = 1 from the first cycle after reset.
- Reset mid-operation discards all in-flight items. No result appears after reset for inputs accepted before it.
- in_* are sampled only on the accept edge and may change freely otherwise.

## Test plan
1. Normal: sign 0, exp 1023, mant = hidden only, RNE -> out_word 0x3FF0000000000000, flags 0, out_valid exactly 2 cycles after accept.
2. Normalization:
   - carry set, exp 1023 -> 0x4000000000000000.
   - hidden 0 with fraction MSB set, exp 1023 -> 0x3FE0000000000000.
3. Rounding: exp 1023, fraction 0x0000000000001, G = 1, R = S = 0.
   - RNE -> 0x3FF0000000000002, inexact 1.
   - RTZ -> 0x3FF0000000000001.
   - Sign 1, RDN -> 0xBFF0000000000002.
4. Overflow: exp 2047, hidden set.
   - RNE -> 0x7FF0000000000000, overflow 1, inexact 1.
   - RTZ -> 0x7FEFFFFFFFFFFFFF.
   - Fraction all ones with G = 1, exp 2046, RNE -> rounds to inf.
5. Subnormal and specials:
   - exp 0, hidden set, exact -> 0x0008000000000000, underflow 0.
   - Same with S = 1 -> underflow 1, inexact 1.
   - nan -> 0x7FF8000000000000.
   - sign 1 zero -> 0x8000000000000000.
6. Handshake and reset:
   - Send 4 back-to-back items with out_ready low -> in_ready drops after 2 accepts and out_word holds.
   - Release out_ready -> all 4 results emerge in order.
   - Assert rst with 2 in flight -> out_valid 0 the next cycle and no stale outputs afterward.
